// File: rtl/show_number_pkg.sv
// Shared constants for the multiplexed 7-segment display: default geometry
// and the high-true gfedcba encodings for hex digits 0..F.
package show_number_pkg;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_CLK_DIV    = 100000;
  localparam int DEF_DEAD       = 2;
  localparam int DEF_ACTIVE_LOW = 1;

  typedef logic [6:0] seg7_t;

  // Index 15 is listed first: F, E, d, C, b, A, 9 .. 0.
  localparam seg7_t [15:0] SEG_HI = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to high-true gfedcba segment pattern.
module hex_to_7seg
  import show_number_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_HI[hex];

endmodule

// File: rtl/show_number_scan.sv
// Time-multiplexed hex display scanner with frame-synchronous number updates,
// dead-time between digits, leading-zero blanking and selectable polarity.
module show_number_scan
  import show_number_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int DEAD       = DEF_DEAD,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] number,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic                    blank,
  output logic [7:0]              ss_out,
  output logic [NUM_DIGITS-1:0]   ss_digit,
  output logic                    frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DEAD_CNT  = PW'(DEAD);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  // XOR masks that turn high-true patterns into the pin polarity.
  localparam logic [7:0]            SEG_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]           presc_reg, presc_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic                    pending_reg, pending_next;
  logic [4*NUM_DIGITS-1:0] stage_num_reg, stage_num_next;
  logic [NUM_DIGITS-1:0]   stage_dp_reg, stage_dp_next;
  logic [4*NUM_DIGITS-1:0] shadow_num_reg, shadow_num_next;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg, shadow_dp_next;
  logic [7:0]              ss_out_reg, ss_out_next;
  logic [NUM_DIGITS-1:0]   ss_digit_reg, ss_digit_next;

  logic                    slot_wrap;
  logic                    frame_wrap;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [NUM_DIGITS-1:0]   digit_hi;
  logic [7:0]              seg_hi;

  assign slot_wrap  = (presc_reg == PRESC_MAX);
  assign frame_wrap = slot_wrap && (idx_reg == IDX_MAX);
  assign cur_nib    = shadow_num_reg[{idx_reg, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex (cur_nib),
    .seg (cur_seg)
  );

  // A digit is a leading zero when it and every digit to its left are zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign suppress[gi] = 1'b0;
      end else begin : g_upper
        assign suppress[gi] = lz_suppress &&
                              (shadow_num_reg[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  always_comb begin
    presc_next      = presc_reg + PW'(1);
    idx_next        = idx_reg;
    pending_next    = pending_reg;
    stage_num_next  = stage_num_reg;
    stage_dp_next   = stage_dp_reg;
    shadow_num_next = shadow_num_reg;
    shadow_dp_next  = shadow_dp_reg;

    if (slot_wrap) begin
      presc_next = '0;
      idx_next   = (idx_reg == IDX_MAX) ? '0 : idx_reg + IW'(1);
    end

    if (frame_wrap && pending_reg) begin
      shadow_num_next = stage_num_reg;
      shadow_dp_next  = stage_dp_reg;
    end

    // A load in the boundary cycle re-arms pending for the following frame.
    if (load) begin
      stage_num_next = number;
      stage_dp_next  = dp;
      pending_next   = 1'b1;
    end else if (frame_wrap) begin
      pending_next = 1'b0;
    end
  end

  always_comb begin
    digit_hi = '0;
    if ((presc_reg >= DEAD_CNT) && !blank && !suppress[idx_reg]) begin
      digit_hi = NUM_DIGITS'(1) << idx_reg;
    end
    seg_hi        = {shadow_dp_reg[idx_reg], cur_seg};
    ss_digit_next = digit_hi ^ DIGIT_OFF;
    ss_out_next   = seg_hi ^ SEG_OFF;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg      <= '0;
      idx_reg        <= '0;
      pending_reg    <= 1'b0;
      stage_num_reg  <= '0;
      stage_dp_reg   <= '0;
      shadow_num_reg <= '0;
      shadow_dp_reg  <= '0;
      ss_out_reg     <= SEG_OFF;
      ss_digit_reg   <= DIGIT_OFF;
    end else begin
      presc_reg      <= presc_next;
      idx_reg        <= idx_next;
      pending_reg    <= pending_next;
      stage_num_reg  <= stage_num_next;
      stage_dp_reg   <= stage_dp_next;
      shadow_num_reg <= shadow_num_next;
      shadow_dp_reg  <= shadow_dp_next;
      ss_out_reg     <= ss_out_next;
      ss_digit_reg   <= ss_digit_next;
    end
  end

  assign ss_out     = ss_out_reg;
  assign ss_digit   = ss_digit_reg;
  assign frame_done = frame_wrap;

endmodule

// File: tb/tb_show_number_scan.sv
// Scoreboard bench for show_number_scan with a 4-digit, 4-cycle-slot,
// 1-cycle-dead, active-low configuration.
module tb_show_number_scan;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] number;
  logic [3:0]  dp;
  logic        load;
  logic        lz_suppress;
  logic        blank;
  logic [7:0]  ss_out;
  logic [3:0]  ss_digit;
  logic        frame_done;

  always #5 clock = ~clock;

  show_number_scan #(
    .NUM_DIGITS (4),
    .CLK_DIV    (4),
    .DEAD       (1),
    .ACTIVE_LOW (1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .number      (number),
    .dp          (dp),
    .load        (load),
    .lz_suppress (lz_suppress),
    .blank       (blank),
    .ss_out      (ss_out),
    .ss_digit    (ss_digit),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic       fd;
    logic [3:0] digit;
    logic [7:0] seg;
  } sb_t;

  sb_t exp_q[$];
  sb_t obs_q[$];
  int  total = 0;
  int  bad   = 0;

  // Reference model state
  int          m_presc;
  int          m_idx;
  logic        m_pend;
  logic [15:0] m_stage_num;
  logic [15:0] m_shad_num;
  logic [3:0]  m_stage_dp;
  logic [3:0]  m_shad_dp;

  logic [3:0]  last_digit;
  logic [7:0]  last_seg;
  logic        last_fd;
  logic [7:0]  seen [4];
  int          cnt  [4];

  // Active-low codes with dp off
  function automatic logic [7:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic model_reset();
    m_presc = 0; m_idx = 0; m_pend = 1'b0;
    m_stage_num = '0; m_shad_num = '0; m_stage_dp = '0; m_shad_dp = '0;
  endtask

  // One clock: predict, advance model, capture DUT outputs; starts and ends at negedge.
  task automatic step();
    sb_t        e;
    sb_t        o;
    logic [3:0] nib;
    logic [3:0] mask;
    logic       supp;
    logic       en;
    logic       fd;
    nib  = m_shad_num[4*m_idx +: 4];
    supp = lz_suppress && (m_idx > 0) && ((m_shad_num >> (4*m_idx)) == 16'h0);
    en   = (m_presc >= 1) && !blank && !supp;
    mask = 4'b0001 << m_idx;
    e.fd    = (m_presc == 3) && (m_idx == 3);
    e.digit = en ? ~mask : 4'b1111;
    e.seg   = seg_code(nib);
    if (m_shad_dp[m_idx]) e.seg[7] = 1'b0;
    o.fd = frame_done;
    @(posedge clock);
    fd = e.fd;
    if (m_presc == 3) begin
      m_presc = 0;
      m_idx   = (m_idx == 3) ? 0 : m_idx + 1;
    end else begin
      m_presc = m_presc + 1;
    end
    if (fd && m_pend) begin
      m_shad_num = m_stage_num;
      m_shad_dp  = m_stage_dp;
    end
    if (load) begin
      m_stage_num = number;
      m_stage_dp  = dp;
      m_pend      = 1'b1;
    end else if (fd) begin
      m_pend = 1'b0;
    end
    @(negedge clock);
    o.digit = ss_digit;
    o.seg   = ss_out;
    exp_q.push_back(e);
    obs_q.push_back(o);
    last_digit = o.digit;
    last_seg   = o.seg;
    last_fd    = o.fd;
  endtask

  task automatic load_value(input logic [15:0] n, input logic [3:0] d);
    number = n; dp = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_until_fd(output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (last_fd) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  // Scan one whole frame, recording per-digit enable count and segment value.
  task automatic collect_frame();
    logic [3:0] mask;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 8'h00;
      cnt[i]  = 0;
    end
    for (int s = 0; s < 16; s++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        mask = 4'b0001 << i;
        if (last_digit == ~mask) begin
          cnt[i]++;
          seen[i] = last_seg;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; number = '0; dp = '0; load = 1'b0; lz_suppress = 1'b0; blank = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    total++;
    if (ss_digit !== 4'hF) begin bad++; $display("FAIL reset_digit got=%h want=%h", ss_digit, 4'hF); end
    total++;
    if (ss_out !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=%h", ss_out, 8'hFF); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
    reset_n = 1'b1;
    $display("test_reset: checks=%0d", total);
  endtask

  task automatic test_scan_zero();
    logic [3:0] seq [8];
    int         fd_at [$];
    sb_t        e;
    sb_t        o;
    seq = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101};
    for (int s = 0; s < 48; s++) begin
      step();
      if (s < 8) begin
        total++;
        if (last_digit !== seq[s])
          begin bad++; $display("FAIL scan_seq[%0d] got=%b want=%b", s, last_digit, seq[s]); end
      end
      if (last_fd) fd_at.push_back(s);
    end
    total++;
    if (fd_at.size() != 3) begin bad++; $display("FAIL fd_count got=%0d want=3", fd_at.size()); end
    else begin
      total++;
      if (fd_at[0] != 15 || fd_at[1] - fd_at[0] != 16 || fd_at[2] - fd_at[1] != 16)
        begin bad++; $display("FAIL fd_spacing got=%0d,%0d,%0d want=15,31,47", fd_at[0], fd_at[1], fd_at[2]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL scan_zero_sb got=%h want=%h", o, e); end
    end
    $display("test_scan_zero: checks=%0d", total);
  endtask

  task automatic test_load();
    logic [7:0] want [4];
    bit         early;
    bit         hit;
    sb_t        e;
    sb_t        o;
    want  = '{8'hA4, 8'h99, 8'h80, 8'h88};
    early = 1'b0;
    hit   = 1'b0;
    load_value(16'hA842, 4'b0000);
    for (int k = 0; k < 40; k++) begin
      step();
      if (last_fd) begin hit = 1'b1; break; end
      if (last_digit != 4'hF && last_seg != 8'hC0) early = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL load_fd_timeout got=0 want=1"); end
    total++;
    if (early) begin bad++; $display("FAIL load_early got=1 want=0"); end
    collect_frame();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seen[i] !== want[i]) begin bad++; $display("FAIL load_digit%0d got=%h want=%h", i, seen[i], want[i]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL load_sb got=%h want=%h", o, e); end
    end
    $display("test_load: checks=%0d", total);
  endtask

  task automatic test_lz_suppress();
    bit  hit;
    sb_t e;
    sb_t o;
    lz_suppress = 1'b1;
    load_value(16'h0042, 4'b0000);
    run_until_fd(hit);
    total++;
    if (!hit) begin bad++; $display("FAIL lz_fd_timeout got=0 want=1"); end
    collect_frame();
    total++;
    if (cnt[3] != 0 || cnt[2] != 0) begin bad++; $display("FAIL lz_upper_en got=%0d,%0d want=0,0", cnt[3], cnt[2]); end
    total++;
    if (cnt[1] != 3 || seen[1] !== 8'h99) begin bad++; $display("FAIL lz_digit1 got=%0d/%h want=3/99", cnt[1], seen[1]); end
    total++;
    if (cnt[0] != 3 || seen[0] !== 8'hA4) begin bad++; $display("FAIL lz_digit0 got=%0d/%h want=3/a4", cnt[0], seen[0]); end
    load_value(16'h0000, 4'b0000);
    run_until_fd(hit);
    total++;
    if (!hit) begin bad++; $display("FAIL lz0_fd_timeout got=0 want=1"); end
    collect_frame();
    total++;
    if (cnt[1] + cnt[2] + cnt[3] != 0) begin bad++; $display("FAIL lz0_upper_en got=%0d want=0", cnt[1] + cnt[2] + cnt[3]); end
    total++;
    if (cnt[0] != 3 || seen[0] !== 8'hC0) begin bad++; $display("FAIL lz0_digit0 got=%0d/%h want=3/c0", cnt[0], seen[0]); end
    lz_suppress = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL lz_sb got=%h want=%h", o, e); end
    end
    $display("test_lz_suppress: checks=%0d", total);
  endtask

  task automatic test_dp_blank();
    bit  hit;
    int  en_cnt;
    int  fd_cnt;
    sb_t e;
    sb_t o;
    load_value(16'h0100, 4'b0100);
    run_until_fd(hit);
    total++;
    if (!hit) begin bad++; $display("FAIL dp_fd_timeout got=0 want=1"); end
    collect_frame();
    total++;
    if (seen[2] !== 8'h79) begin bad++; $display("FAIL dp_digit2 got=%h want=79", seen[2]); end
    total++;
    if (seen[0] !== 8'hC0 || seen[1] !== 8'hC0 || seen[3] !== 8'hC0)
      begin bad++; $display("FAIL dp_others got=%h,%h,%h want=c0,c0,c0", seen[0], seen[1], seen[3]); end
    blank  = 1'b1;
    en_cnt = 0;
    fd_cnt = 0;
    for (int s = 0; s < 32; s++) begin
      step();
      if (last_digit != 4'hF) en_cnt++;
      if (last_fd) fd_cnt++;
    end
    blank = 1'b0;
    total++;
    if (en_cnt != 0) begin bad++; $display("FAIL blank_enables got=%0d want=0", en_cnt); end
    total++;
    if (fd_cnt != 2) begin bad++; $display("FAIL blank_fd got=%0d want=2", fd_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL dp_blank_sb got=%h want=%h", o, e); end
    end
    $display("test_dp_blank: checks=%0d", total);
  endtask

  task automatic test_back_to_back();
    int  guard;
    sb_t e;
    sb_t o;
    load_value(16'h1111, 4'b0000);
    step(); step(); step();
    load_value(16'h2222, 4'b0000);
    guard = 0;
    while (!(m_presc == 3 && m_idx == 3) && guard < 40) begin
      step();
      guard++;
    end
    total++;
    if (guard >= 40) begin bad++; $display("FAIL b2b_timeout got=%0d want<40", guard); end
    load_value(16'h3333, 4'b0000);
    total++;
    if (last_fd !== 1'b1) begin bad++; $display("FAIL b2b_coincident_fd got=%b want=1", last_fd); end
    collect_frame();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seen[i] !== 8'hA4) begin bad++; $display("FAIL b2b_first_digit%0d got=%h want=a4", i, seen[i]); end
    end
    collect_frame();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seen[i] !== 8'hB0) begin bad++; $display("FAIL b2b_next_digit%0d got=%h want=b0", i, seen[i]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL b2b_sb got=%h want=%h", o, e); end
    end
    $display("test_back_to_back: checks=%0d", total);
  endtask

  task automatic test_reset_mid();
    bit  hit;
    sb_t e;
    sb_t o;
    load_value(16'h5555, 4'b1111);
    step(); step(); step(); step(); step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL rst_mid_pre_sb got=%h want=%h", o, e); end
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (ss_digit !== 4'hF || ss_out !== 8'hFF || frame_done !== 1'b0)
      begin bad++; $display("FAIL rst_mid_async got=%h/%h/%b want=f/ff/0", ss_digit, ss_out, frame_done); end
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    total++;
    if (last_digit !== 4'b1111) begin bad++; $display("FAIL rst_mid_first got=%b want=1111", last_digit); end
    step();
    total++;
    if (last_digit !== 4'b1110 || last_seg !== 8'hC0)
      begin bad++; $display("FAIL rst_mid_digit0 got=%b/%h want=1110/c0", last_digit, last_seg); end
    run_until_fd(hit);
    total++;
    if (!hit) begin bad++; $display("FAIL rst_mid_fd_timeout got=0 want=1"); end
    collect_frame();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seen[i] !== 8'hC0) begin bad++; $display("FAIL rst_mid_shadow%0d got=%h want=c0", i, seen[i]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL rst_mid_sb got=%h want=%h", o, e); end
    end
    $display("test_reset_mid: checks=%0d", total);
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_load();
    test_lz_suppress();
    test_dp_blank();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/show_number_scan.md
SHOW_NUMBER_SCAN -- requirements
Module: show_number_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 The block SHALL have parameter CLK_DIV, default 100000, clock cycles per digit slot (>= DEAD+2).
REQ-003 The block SHALL have parameter DEAD, default 2, cycles per slot with all digits off (anti-ghosting).
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1; 1 = segments and digit enables low-true, 0 = high-true.
REQ-005 The block SHALL have port clock, input, 1 bit, single system clock, all logic on rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port number, input, 4*NUM_DIGITS bits, hex nibble per digit, digit i at [4i+3:4i], digit 0 rightmost.
REQ-008 The block SHALL have port dp, input, NUM_DIGITS bits, decimal point request per digit.
REQ-009 The block SHALL have port load, input, 1 bit, single-cycle strobe requesting capture of number/dp.
REQ-010 The block SHALL have port lz_suppress, input, 1 bit, blanks leading zeros when 1.
REQ-011 The block SHALL have port blank, input, 1 bit, forces all digits off when 1.
REQ-012 The block SHALL have port ss_out, output, 8 bits, [7]=dp, [6:0]=gfedcba.
REQ-013 The block SHALL have port ss_digit, output, NUM_DIGITS bits, one-hot digit enable.
REQ-014 The block SHALL have port frame_done, output, 1 bit, one-cycle pulse at end of each full scan.

Function
REQ-015 A prescaler SHALL count 0..CLK_DIV-1 and wrap; at the wrap, digit index SHALL advance by 1, and wrap from NUM_DIGITS-1 to 0.
REQ-016 frame_done SHALL assert for exactly the one cycle in which the index wraps from NUM_DIGITS-1 to 0.
REQ-017 A load strobe SHALL set a pending flag and capture number/dp into a staging register; a later load before the frame ends SHALL overwrite the staging register.
REQ-018 Staging contents SHALL move into the display shadow register only in the frame_done cycle, and only if pending; pending then clears.
REQ-019 load coincident with frame_done SHALL be captured to staging and applied at the next frame boundary, not the current one.
REQ-020 While prescaler < DEAD, ss_digit SHALL be all inactive.
REQ-021 Otherwise, exactly the current digit's enable SHALL be active, unless blank=1 or that digit is suppressed.
REQ-022 Digit i SHALL be suppressed when lz_suppress=1, i>0, and all shadow nibbles i..NUM_DIGITS-1 are zero; digit 0 SHALL never be suppressed.
REQ-023 ss_out[6:0] SHALL be the hex decode (0-9, A, b, C, d, E, F) of the current digit's shadow nibble.
REQ-024 ss_out[7] SHALL reflect the current digit's shadow dp bit.
REQ-025 Polarity inversion SHALL apply to ss_out and ss_digit together per ACTIVE_LOW.
REQ-026 ss_out and ss_digit SHALL be registered outputs: one cycle latency from index/prescaler state.
REQ-027 blank SHALL take effect on the next clock without disturbing prescaler, index, or load handling.

Reset
REQ-028 While reset_n=0: prescaler=0, index=0, pending=0, staging=0, shadow=0, frame_done=0.
REQ-029 While reset_n=0, ss_digit and ss_out SHALL be all inactive: all ones when ACTIVE_LOW=1.
REQ-030 Reset mid-scan or with load pending SHALL discard the pending load.
REQ-031 Scanning SHALL restart at digit 0 in dead-time on the first clock after release.

Structure
REQ-032 Segment encodings (16 x 7-bit, high-true) and the default parameter values SHALL live in shared package show_number_pkg.
REQ-033 Hex-to-segment decoding SHALL be a combinational sub-module hex_to_7seg (4-bit in, 7-bit high-true out); the scanner SHALL apply polarity.

Verification
Bench uses CLK_DIV=4, DEAD=1, NUM_DIGITS=4, ACTIVE_LOW=1.
REQ-034 Reset release, number=0 -> ss_digit sequence 1111,1110x3, then 1101x3 after 1111, ...; ss_out=0xC0; frame_done every 16 cycles.
REQ-035 load with number=16'hA842, dp=0 -> shown only after next frame_done; digits 0..3 show ss_out 0xA4, 0x99, 0x80, 0x88.
REQ-036 number=16'h0042, lz_suppress=1 -> digits 3,2 never enabled; digits 1,0 show 0x99, 0xA4; number=0 -> only digit 0 enabled, showing 0xC0.
REQ-037 dp=4'b0100 with digit 2=1 -> ss_out=0x79 on digit 2 only; blank=1 -> ss_digit stays 1111 while frame_done keeps pulsing.
REQ-038 Two loads (0x1111 then 0x2222) in one frame, plus load exactly on frame_done -> only 0x2222 appears; the frame_done-coincident value appears one frame later.
REQ-039 reset_n low mid-slot with load pending -> outputs all ones immediately; after release, shadow=0 and scan starts at digit 0.
